ddr3_cache_nway: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate line cache between the core's data port and the DDR3 controller FIFOs.
- Hits complete in one cycle.
- Misses evict the dirty victim line into the write FIFO, request the line through the read-in FIFO, and refill from the read-out FIFO.
- Line width, set count, associativity and address width are parameters; replacement is per-set round-robin.

---
 rtl/ddr3_cache_pkg.sv | 33 +++
 rtl/ddr3_cache_nway_if.sv | 49 ++++
 rtl/ddr3_cache_set_lookup.sv | 33 +++
 rtl/ddr3_cache_nway.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ddr3_cache_nway.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_cache_pkg.sv
// Shared definitions for the ddr3_cache_nway line cache: default geometry,
// FSM state codes and address field extraction helpers.
package ddr3_cache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_SETS       = 64;
    localparam int DEF_WAYS       = 2;
    localparam int DEF_LINE_WORDS = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_EVICT = 3'd1;
    localparam state_t ST_REQ   = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Tag field: everything above the index and offset bits.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off_w, input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

    // Set index field, directly above the line offset.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int off_w, input int idx_w);
        return (addr >> off_w) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // 32-bit word number inside the line; byte-lane bits [1:0] are dropped.
    function automatic logic [63:0] addr_word(input logic [63:0] addr, input int off_w);
        return (addr >> 2) & ((64'd1 << (off_w - 2)) - 64'd1);
    endfunction

endpackage

// File: rtl/ddr3_cache_nway_if.sv
// Core request/response port plus the three DDR3 controller FIFO ports.
// The cache side uses the slave modport, the core/FIFO side the master modport.
interface ddr3_cache_nway_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_rdata;

    logic              wb_push;
    logic              wb_full;
    logic [ADDR_W-1:0] wb_addr;
    logic [LINE_W-1:0] wb_data;

    logic              rd_req_push;
    logic              rd_req_full;
    logic [ADDR_W-1:0] rd_req_addr;

    logic              rd_rsp_empty;
    logic [LINE_W-1:0] rd_rsp_data;
    logic              rd_rsp_pop;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output wb_push, wb_addr, wb_data,
        input  wb_full,
        output rd_req_push, rd_req_addr,
        input  rd_req_full,
        input  rd_rsp_empty, rd_rsp_data,
        output rd_rsp_pop
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  wb_push, wb_addr, wb_data,
        output wb_full,
        input  rd_req_push, rd_req_addr,
        output rd_req_full,
        output rd_rsp_empty, rd_rsp_data,
        input  rd_rsp_pop
    );
endinterface

// File: rtl/ddr3_cache_set_lookup.sv
// Combinational tag compare across all ways of one set. Reports hit, the
// hitting way, and whether the round-robin victim holds dirty valid data.
module ddr3_cache_set_lookup #(
    parameter int WAYS  = 2,
    parameter int TAG_W = 22,
    parameter int WAY_W = 1
) (
    input  logic [TAG_W-1:0]            tag,
    input  logic [WAYS-1:0][TAG_W-1:0]  set_tags,
    input  logic [WAYS-1:0]             set_valid,
    input  logic [WAYS-1:0]             set_dirty,
    input  logic [WAY_W-1:0]            rr_ptr,
    output logic                        hit,
    output logic [WAY_W-1:0]            hit_way,
    output logic                        victim_dirty
);

    // Compare every valid way; the cache never holds a tag twice in one set.
    always_comb begin
        hit     = 1'b0;
        hit_way = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (set_valid[w] && (set_tags[w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end else begin
                hit     = hit;
            end
        end
        victim_dirty = set_valid[rr_ptr] & set_dirty[rr_ptr];
    end

endmodule

// File: rtl/ddr3_cache_nway.sv
// N-way set-associative, write-back, write-allocate line cache in front of
// the DDR3 controller FIFOs. Hits answer next cycle; misses write back a
// dirty round-robin victim, request the line and refill it.
// Optional build macro: CACHE_STATS_EN adds saturating hit/miss/evict counters.
module ddr3_cache_nway
    import ddr3_cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = DEF_WAYS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic               clk,
    input  logic               reset_n,
    ddr3_cache_nway_if.slave   bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        stat_hits,
    output logic [31:0]        stat_misses,
    output logic [31:0]        stat_evicts
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int WRD_W  = $clog2(LINE_WORDS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t                          state_q, state_d;
    logic                            req_write_q, req_write_d;
    logic [ADDR_W-1:0]               req_addr_q, req_addr_d;
    logic [31:0]                     req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]                victim_q, victim_d;
    logic                            resp_valid_q, resp_valid_d;
    logic [31:0]                     resp_rdata_q, resp_rdata_d;
    logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0]       dirty_q, dirty_d;
    logic [SETS-1:0][WAY_W-1:0]      rr_q, rr_d;

    // Line storage, deliberately without reset.
    logic [LINE_W-1:0]               data_q [SETS][WAYS];
    logic [TAG_W-1:0]                tag_q  [SETS][WAYS];

    logic                            arr_we_d;
    logic                            tag_we_d;
    logic [WAY_W-1:0]                arr_way_d;
    logic [LINE_W-1:0]               arr_line_d;

    logic [ADDR_W-1:0]               cur_addr_s;
    logic [TAG_W-1:0]                tag_s;
    logic [IDX_W-1:0]                idx_s;
    logic [WRD_W-1:0]                word_s;
    logic [WAYS-1:0][TAG_W-1:0]      set_tags_s;
    logic                            hit_s;
    logic [WAY_W-1:0]                hit_way_s;
    logic                            victim_dirty_s;
    logic [LINE_W-1:0]               hit_line_s;
    logic                            wb_push_s;
    logic                            rd_req_push_s;
    logic                            rd_rsp_pop_s;

    // The live request drives the lookup in IDLE; afterwards the captured one does.
    assign cur_addr_s = (state_q == ST_IDLE) ? bus.req_addr : req_addr_q;
    assign tag_s      = TAG_W'(addr_tag(64'(cur_addr_s), OFF_W, IDX_W));
    assign idx_s      = IDX_W'(addr_index(64'(cur_addr_s), OFF_W, IDX_W));
    assign word_s     = WRD_W'(addr_word(64'(cur_addr_s), OFF_W));
    assign hit_line_s = data_q[idx_s][hit_way_s];

    // Gather the tags of the indexed set for the comparator.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            set_tags_s[w] = tag_q[idx_s][w];
        end
    end

    ddr3_cache_set_lookup #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .WAY_W (WAY_W)
    ) u_lookup (
        .tag          (tag_s),
        .set_tags     (set_tags_s),
        .set_valid    (valid_q[idx_s]),
        .set_dirty    (dirty_q[idx_s]),
        .rr_ptr       (rr_q[idx_s]),
        .hit          (hit_s),
        .hit_way      (hit_way_s),
        .victim_dirty (victim_dirty_s)
    );

    // Next-state, bookkeeping and array-write decisions for the miss FSM.
    always_comb begin
        state_d      = state_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        rr_d         = rr_q;
        arr_we_d     = 1'b0;
        tag_we_d     = 1'b0;
        arr_way_d    = hit_way_s;
        arr_line_d   = hit_line_s;
        wb_push_s    = 1'b0;
        rd_req_push_s = 1'b0;
        rd_rsp_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_write_d = bus.req_write;
                    req_addr_d  = bus.req_addr;
                    req_wdata_d = bus.req_wdata;
                    if (hit_s) begin
                        resp_valid_d = 1'b1;
                        if (bus.req_write) begin
                            arr_we_d = 1'b1;
                            arr_line_d[{word_s, 5'b00000} +: 32] = bus.req_wdata;
                            dirty_d[idx_s][hit_way_s] = 1'b1;
                        end else begin
                            resp_rdata_d = hit_line_s[{word_s, 5'b00000} +: 32];
                        end
                    end else begin
                        victim_d = rr_q[idx_s];
                        state_d  = victim_dirty_s ? ST_EVICT : ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVICT: begin
                if (!bus.wb_full) begin
                    wb_push_s = 1'b1;
                    valid_d[idx_s][victim_q] = 1'b0;
                    dirty_d[idx_s][victim_q] = 1'b0;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_EVICT;
                end
            end
            ST_REQ: begin
                if (!bus.rd_req_full) begin
                    rd_req_push_s = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (!bus.rd_rsp_empty) begin
                    rd_rsp_pop_s = 1'b1;
                    arr_we_d     = 1'b1;
                    tag_we_d     = 1'b1;
                    arr_way_d    = victim_q;
                    arr_line_d   = bus.rd_rsp_data;
                    if (req_write_q) begin
                        arr_line_d[{word_s, 5'b00000} +: 32] = req_wdata_q;
                    end else begin
                        resp_rdata_d = bus.rd_rsp_data[{word_s, 5'b00000} +: 32];
                    end
                    valid_d[idx_s][victim_q] = 1'b1;
                    dirty_d[idx_s][victim_q] = req_write_q;
                    rr_d[idx_s] = (rr_q[idx_s] == WAY_W'(WAYS - 1)) ? {WAY_W{1'b0}}
                                                                    : rr_q[idx_s] + WAY_W'(1);
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, valid/dirty bits and round-robin pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_write_q  <= 1'b0;
            req_addr_q   <= {ADDR_W{1'b0}};
            req_wdata_q  <= 32'h0000_0000;
            victim_q     <= {WAY_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            valid_q      <= {(SETS * WAYS){1'b0}};
            dirty_q      <= {(SETS * WAYS){1'b0}};
            rr_q         <= {(SETS * WAY_W){1'b0}};
        end else begin
            state_q      <= state_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            rr_q         <= rr_d;
        end
    end

    // Line and tag storage updates for write hits and refills.
    always_ff @(posedge clk) begin
        if (arr_we_d) begin
            data_q[idx_s][arr_way_d] <= arr_line_d;
        end
        if (tag_we_d) begin
            tag_q[idx_s][arr_way_d] <= tag_s;
        end
    end

    assign bus.req_ready   = reset_n & (state_q == ST_IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    // FIFO strobes react to the full/empty flags in the same cycle.
    assign bus.wb_push     = wb_push_s;
    assign bus.wb_addr     = (state_q == ST_EVICT) ? {tag_q[idx_s][victim_q], idx_s, {OFF_W{1'b0}}}
                                                   : {ADDR_W{1'b0}};
    assign bus.wb_data     = (state_q == ST_EVICT) ? data_q[idx_s][victim_q] : {LINE_W{1'b0}};
    assign bus.rd_req_push = rd_req_push_s;
    assign bus.rd_req_addr = (state_q == ST_REQ) ? {tag_s, idx_s, {OFF_W{1'b0}}} : {ADDR_W{1'b0}};
    assign bus.rd_rsp_pop  = rd_rsp_pop_s;

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;
    logic [31:0] stat_evicts_q, stat_evicts_d;
    logic        accept_s;

    assign accept_s = (state_q == ST_IDLE) & bus.req_valid;

    // Saturating event counters.
    always_comb begin
        stat_hits_d   = (accept_s && hit_s && (stat_hits_q != 32'hFFFF_FFFF))
                        ? stat_hits_q + 32'd1 : stat_hits_q;
        stat_misses_d = (accept_s && !hit_s && (stat_misses_q != 32'hFFFF_FFFF))
                        ? stat_misses_q + 32'd1 : stat_misses_q;
        stat_evicts_d = (wb_push_s && (stat_evicts_q != 32'hFFFF_FFFF))
                        ? stat_evicts_q + 32'd1 : stat_evicts_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits_q   <= 32'h0000_0000;
            stat_misses_q <= 32'h0000_0000;
            stat_evicts_q <= 32'h0000_0000;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
            stat_evicts_q <= stat_evicts_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_evicts = stat_evicts_q;
`endif

endmodule

// File: tb/tb_ddr3_cache_nway.sv
// Self-checking bench for ddr3_cache_nway (default geometry). The bench plays
// core and DDR3 FIFOs; a memory-level reference (architectural contents, DDR
// contents, per-set residency with round-robin) predicts every response,
// write-back and request. Build with CACHE_STATS_EN to also check counters.
module tb_ddr3_cache_nway;

    localparam int SETS = 64;
    localparam int WAYS = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    ddr3_cache_nway_if #(.ADDR_W(32), .LINE_W(128)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_evicts;
`endif

    ddr3_cache_nway #(.ADDR_W(32), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
        .stat_evicts (stat_evicts)
`endif
    );

    always #5 clk = ~clk;

    // Reference state: what the core should see, what DDR holds, residency.
    logic [127:0] arch [logic [31:0]];
    logic [127:0] ddr  [logic [31:0]];
    bit           m_valid [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [31:0]  m_tag   [SETS][WAYS];
    int           m_rr    [SETS];

    bit           last_hit, last_evict;
    logic [31:0]  o_rdata, o_wb_addr, o_rq_addr;
    logic [127:0] o_wb_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic touch(input logic [31:0] la);
        logic [127:0] l;
        if (!ddr.exists(la)) begin
            l = {$urandom(), $urandom(), $urandom(), $urandom()};
            ddr[la]  = l;
            arch[la] = l;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        arch = ddr;
    endtask

    // One core request with stall counts for write FIFO, read-in and read-out.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int wst, input int rqst, input int pst);
        logic [31:0]  la, tg, ev_addr, want_rdata;
        logic [127:0] line, ev_line, fill_line;
        int set, wrd, hway, vway, e_end, rq_cyc, pop_cyc, lat;
        int n_wb, n_rq, n_pop, n_resp, c_wb, c_rq, c_pop, c_resp;
        bit hit, evict, ready_bad;
        la  = addr & 32'hFFFF_FFF0;
        set = int'((addr >> 4) % SETS);
        tg  = addr >> 10;
        wrd = int'((addr >> 2) % 4);
        touch(la);
        hit = 1'b0; hway = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[set][w] && m_tag[set][w] == tg) begin hit = 1'b1; hway = w; end
        end
        vway    = m_rr[set];
        evict   = !hit && m_valid[set][vway] && m_dirty[set][vway];
        ev_addr = (m_tag[set][vway] << 10) | (32'(set) << 4);
        ev_line = 128'h0;
        if (evict) ev_line = arch[ev_addr];
        line       = arch[la];
        fill_line  = ddr[la];
        want_rdata = wr ? 32'h0 : line[wrd*32 +: 32];
        e_end   = evict ? wst + 1 : 0;
        rq_cyc  = e_end + rqst + 1;
        pop_cyc = rq_cyc + pst + 1;
        lat     = hit ? 1 : pop_cyc + 1;
        // reference update
        if (evict) begin ddr[ev_addr] = ev_line; m_valid[set][vway] = 1'b0; end
        if (wr) begin line[wrd*32 +: 32] = wd; arch[la] = line; end
        if (hit) begin
            if (wr) m_dirty[set][hway] = 1'b1;
        end else begin
            m_valid[set][vway] = 1'b1;
            m_dirty[set][vway] = wr;
            m_tag[set][vway]   = tg;
            m_rr[set]          = (vway + 1) % WAYS;
        end
        // drive and observe
        n_wb = 0; n_rq = 0; n_pop = 0; n_resp = 0;
        c_wb = -1; c_rq = -1; c_pop = -1; c_resp = -1; ready_bad = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd;
        bus.rd_rsp_data = fill_line;
        bus.wb_full = !hit; bus.rd_req_full = !hit; bus.rd_rsp_empty = !hit;
        #1;
        chk("accept_ready", 128'(bus.req_ready), 128'(1'b1));
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (!hit) begin
                bus.wb_full      = (k <= wst);
                bus.rd_req_full  = (k <= e_end + rqst);
                bus.rd_rsp_empty = (k < pop_cyc);
            end
            #1;
            if (bus.wb_push) begin n_wb++; c_wb = k; o_wb_addr = bus.wb_addr; o_wb_data = bus.wb_data; end
            if (bus.rd_req_push) begin n_rq++; c_rq = k; o_rq_addr = bus.rd_req_addr; end
            if (bus.rd_rsp_pop) begin n_pop++; c_pop = k; end
            if (bus.resp_valid) begin n_resp++; c_resp = k; o_rdata = bus.resp_rdata; end
            if (!hit && k <= lat && bus.req_ready !== 1'b0) ready_bad = 1'b1;
        end
        chk("resp_count", 128'(n_resp), 128'(1));
        chk("resp_cycle", 128'(c_resp), 128'(lat));
        chk("resp_rdata", 128'(o_rdata), 128'(want_rdata));
        chk("wb_count", 128'(n_wb), 128'(evict ? 1 : 0));
        chk("rdreq_count", 128'(n_rq), 128'(hit ? 0 : 1));
        chk("pop_count", 128'(n_pop), 128'(hit ? 0 : 1));
        if (evict) begin
            chk("wb_cycle", 128'(c_wb), 128'(e_end));
            chk("wb_addr", 128'(o_wb_addr), 128'(ev_addr));
            chk("wb_data", o_wb_data, ev_line);
        end
        if (!hit) begin
            chk("rdreq_cycle", 128'(c_rq), 128'(rq_cyc));
            chk("rdreq_addr", 128'(o_rq_addr), 128'(la));
            chk("pop_cycle", 128'(c_pop), 128'(pop_cyc));
            chk("ready_low_busy", 128'(ready_bad), 128'(1'b0));
        end
        last_hit = hit; last_evict = evict;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.wb_full = 1'b0; bus.rd_req_full = 1'b0; bus.rd_rsp_empty = 1'b1;
        bus.rd_rsp_data = 128'h0;
        #1 reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 128'({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.wb_push,
                                   bus.wb_addr, bus.rd_req_push, bus.rd_req_addr, bus.rd_rsp_pop}), 128'h0);
        chk("reset_wb_data", bus.wb_data, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_after_reset", 128'(bus.req_ready), 128'(1'b1));

        // Cold read miss
        ddr[32'h1000]  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        arch[32'h1000] = ddr[32'h1000];
        do_req(1'b0, 32'h0000_1004, 32'h0, 0, 0, 0);
        chk("s1_miss", 128'(last_hit), 128'(1'b0));
        chk("s1_rdreq_addr", 128'(o_rq_addr), 128'(32'h0000_1000));
        chk("s1_rdata", 128'(o_rdata), 128'(32'h1111_1111));

        // Read hit
        do_req(1'b0, 32'h0000_100C, 32'h0, 0, 0, 0);
        chk("s2_hit", 128'(last_hit), 128'(1'b1));
        chk("s2_rdata", 128'(o_rdata), 128'(32'h3333_3333));

        // Write hit, fill second way, then evict the dirty line
        do_req(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 0, 0, 0);
        chk("s3_write_hit", 128'(last_hit), 128'(1'b1));
        do_req(1'b0, 32'h0000_1400, 32'h0, 0, 0, 1);
        do_req(1'b0, 32'h0000_1800, 32'h0, 0, 0, 0);
        chk("s3_evict", 128'(last_evict), 128'(1'b1));
        chk("s3_wb_addr", 128'(o_wb_addr), 128'(32'h0000_1000));
        chk("s3_wb_word2", 128'(o_wb_data[95:64]), 128'(32'hDEAD_BEEF));
        chk("s3_rdreq_addr", 128'(o_rq_addr), 128'(32'h0000_1800));
`ifdef CACHE_STATS_EN
        chk("stat_hits", 128'(stat_hits), 128'(32'd2));
        chk("stat_misses", 128'(stat_misses), 128'(32'd3));
        chk("stat_evicts", 128'(stat_evicts), 128'(32'd1));
`endif

        // Backpressure on both write-back and read request
        do_req(1'b1, 32'h0000_1404, 32'hCAFE_F00D, 0, 0, 0);
        do_req(1'b0, 32'h0000_1C08, 32'h0, 5, 3, 2);
        chk("s4_evict", 128'(last_evict), 128'(1'b1));
        chk("s4_wb_addr", 128'(o_wb_addr), 128'(32'h0000_1400));
        chk("s4_wb_word1", 128'(o_wb_data[63:32]), 128'(32'hCAFE_F00D));

        // Reset while waiting for the refill
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_1004;
        bus.wb_full = 1'b0; bus.rd_req_full = 1'b0; bus.rd_rsp_empty = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("s5_rdreq_push", 128'(bus.rd_req_push), 128'(1'b1));
        @(negedge clk);
        #1;
        chk("s5_wait_no_pop", 128'({bus.rd_rsp_pop, bus.resp_valid, bus.req_ready}), 128'(3'b000));
        reset_n = 1'b0;
        bus.rd_rsp_empty = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("s5_in_reset_quiet", 128'({bus.resp_valid, bus.wb_push, bus.rd_req_push,
                                           bus.rd_rsp_pop, bus.req_ready}), 128'(5'b00000));
        end
        reset_n = 1'b1;
        bus.rd_rsp_empty = 1'b1;
        model_reset();
        #1;
        chk("s5_ready_after", 128'(bus.req_ready), 128'(1'b1));
        @(negedge clk);
        #1;
        chk("s5_no_late_resp", 128'({bus.resp_valid, bus.rd_rsp_pop}), 128'(2'b00));
        do_req(1'b0, 32'h0000_1004, 32'h0, 0, 0, 0);
        chk("s5_miss_again", 128'(last_hit), 128'(1'b0));
        chk("s5_rdata", 128'(o_rdata), 128'(32'h1111_1111));

        // Randomised traffic over a few conflicting sets
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(1, 5)) << 10) | (32'($urandom_range(0, 2)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            do_req(1'($urandom_range(0, 1)), a, $urandom(),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
